// File: rtl/ctrl_memory_writer_if.sv
// Request and memory-port bundle for ctrl_memory_writer.
// The master side is the requester together with the memory that answers mem_rdata.
interface ctrl_memory_writer_if #(
  parameter int GRID   = 32,
  parameter int ADDR_W = 6,
  parameter int OFF_W  = 4
);
  localparam int W = GRID * GRID;

  logic                    in_valid;
  logic                    in_ready;
  logic [ADDR_W-1:0]       in_addr;
  logic [W-1:0]            in_data;
  logic signed [OFF_W-1:0] in_off_x;
  logic signed [OFF_W-1:0] in_off_y;
  logic [1:0]              in_mode;
  logic                    mem_rw;
  logic [ADDR_W-1:0]       mem_addr;
  logic [W-1:0]            mem_wdata;
  logic [W-1:0]            mem_rdata;
  logic                    done;

  modport master (
    output in_valid, in_addr, in_data, in_off_x, in_off_y, in_mode, mem_rdata,
    input  in_ready, mem_rw, mem_addr, mem_wdata, done
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_off_x, in_off_y, in_mode, mem_rdata,
    output in_ready, mem_rw, mem_addr, mem_wdata, done
  );
endinterface

// File: rtl/ctrl_memory_writer.sv
// Un-shifts a GRID x GRID bit plane by a signed offset and writes it into one memory word,
// with clipped overwrite, toroidal wrap, or OR-merge (clip/OR read the old word first).
module ctrl_memory_writer #(
  parameter int GRID   = 32,
  parameter int ADDR_W = 6,
  parameter int OFF_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ctrl_memory_writer_if.slave  bus
);
  localparam int W = GRID * GRID;

  typedef enum logic [1:0] {IDLE, SHIFT, MRG, WR} state_t;

  state_t                  r_state, w_next;
  logic [ADDR_W-1:0]       r_addr;
  logic [W-1:0]            r_data;
  logic signed [OFF_W-1:0] r_ox, r_oy;
  logic [1:0]              r_mode;
  logic [W-1:0]            r_s, r_m;

  logic                    r_ready, r_rw, r_done;
  logic [ADDR_W-1:0]       r_maddr;
  logic [W-1:0]            r_wdata;

  logic                    w_hs, w_wrap;
  logic [W-1:0]            w_s, w_m, w_merge;
  logic                    w_ready, w_rw, w_done;
  logic [ADDR_W-1:0]       w_maddr;
  logic [W-1:0]            w_wdata;

  assign w_hs   = bus.in_valid & r_ready;
  assign w_wrap = (r_mode == 2'b01);

  // Gather form: each target bit looks back to its source, so clipped targets simply stay uncovered.
  always_comb begin
    w_s = '0;
    w_m = '0;
    for (int ty = 0; ty < GRID; ty++) begin
      for (int tx = 0; tx < GRID; tx++) begin
        int sx, sy;
        sx = tx - int'(r_ox);
        sy = ty - int'(r_oy);
        if (w_wrap) begin
          sx = (sx + GRID) % GRID;
          sy = (sy + GRID) % GRID;
          w_s[ty*GRID+tx] = r_data[sy*GRID+sx];
          w_m[ty*GRID+tx] = 1'b1;
        end else if (sx >= 0 && sx < GRID && sy >= 0 && sy < GRID) begin
          w_s[ty*GRID+tx] = r_data[sy*GRID+sx];
          w_m[ty*GRID+tx] = 1'b1;
        end
      end
    end
  end

  // Reserved mode 11 falls into the clip merge.
  assign w_merge = (r_mode == 2'b10) ? (bus.mem_rdata | r_s)
                                     : ((bus.mem_rdata & ~r_m) | r_s);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next = SHIFT;
      SHIFT:   w_next = w_wrap ? WR : MRG;
      MRG:     w_next = WR;
      WR:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    w_ready = (w_next == IDLE);
    w_rw    = (w_next != WR);
    w_done  = (w_next == WR);
    w_maddr = w_hs ? bus.in_addr : r_maddr;
    w_wdata = r_wdata;
    if (r_state == SHIFT && w_next == WR) w_wdata = w_s;
    else if (r_state == MRG)              w_wdata = w_merge;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_rw    <= 1'b1;
      r_done  <= 1'b0;
      r_maddr <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_mode  <= '0;
      r_s     <= '0;
      r_m     <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= w_ready;
      r_rw    <= w_rw;
      r_done  <= w_done;
      r_maddr <= w_maddr;
      r_wdata <= w_wdata;
      if (w_hs) begin
        r_addr <= bus.in_addr;
        r_data <= bus.in_data;
        r_ox   <= bus.in_off_x;
        r_oy   <= bus.in_off_y;
        r_mode <= bus.in_mode;
      end
      if (r_state == SHIFT) begin
        r_s <= w_s;
        r_m <= w_m;
      end
    end
  end

  assign bus.in_ready  = r_ready;
  assign bus.mem_rw    = r_rw;
  assign bus.mem_addr  = r_maddr;
  assign bus.mem_wdata = r_wdata;
  assign bus.done      = r_done;
endmodule
